matrix_stream_loader: RTL and testbench

- Assembles the flattened image operand for the 3x3 convolution stage from a serial pixel stream with a valid/ready handshake.
- Pixels arrive in row-major order for a runtime rows x cols frame. Each pixel is written into a max_rows x max_cols flattened register using the convolution engine's addressing.
- Asserts load_done once the frame is complete; the convolution engine uses this as its start condition.
- Sits between the pixel source (testbench, UART or memory reader) and the convolution engine's matrix_data input.

---
 rtl/matrix_stream_loader.sv | 126 ++++++++++++
 tb/tb_matrix_stream_loader.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/matrix_stream_loader.sv
// Serial pixel loader: packs a row-major rows x cols frame into the flattened
// max_rows x max_cols operand of the 3x3 convolution stage. Optional pix_last
// framing check: define MATRIX_LOADER_LAST_CHECK_EN.
module matrix_stream_loader #(
  parameter int unsigned total_bits = 16,
  parameter int unsigned max_rows   = 8,
  parameter int unsigned max_cols   = 8
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  start,
  input  logic [3:0]                            rows,
  input  logic [3:0]                            cols,
  input  logic                                  pix_valid,
  input  logic [total_bits-1:0]                 pix_data,
  input  logic                                  pix_last,
  output logic                                  pix_ready,
  output logic [max_rows*max_cols*total_bits-1:0] matrix_data,
  output logic                                  busy,
  output logic                                  load_done,
  output logic                                  err
);

  localparam int unsigned MAT_W = max_rows * max_cols * total_bits;
  localparam int unsigned IDX_W = $clog2(MAT_W);

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_e;

  state_e             state_q, state_d;
  logic [3:0]         row_q, row_d, col_q, col_d;
  logic [3:0]         rows_q, rows_d, cols_q, cols_d;
  logic [MAT_W-1:0]   matrix_q, matrix_d;
  logic               err_q, err_d;

  logic               size_ok_c;
  logic               final_c;
  logic [IDX_W-1:0]   wr_idx_c;

  assign size_ok_c = (rows >= 4'd3) && (32'(rows) <= max_rows) &&
                     (cols >= 4'd3) && (32'(cols) <= max_cols);
  assign final_c   = (row_q == rows_q - 4'd1) && (col_q == cols_q - 4'd1);
  assign wr_idx_c  = (IDX_W'(row_q) * IDX_W'(max_cols) + IDX_W'(col_q)) * IDX_W'(total_bits);

`ifndef MATRIX_LOADER_LAST_CHECK_EN
  logic unused_last;
  assign unused_last = pix_last;
`endif

  // Next-state: frame acceptance, slot write and row-major counter advance.
  always_comb begin
    state_d  = state_q;
    row_d    = row_q;
    col_d    = col_q;
    rows_d   = rows_q;
    cols_d   = cols_q;
    matrix_d = matrix_q;
    err_d    = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          if (size_ok_c) begin
            rows_d   = rows;
            cols_d   = cols;
            row_d    = 4'd0;
            col_d    = 4'd0;
            matrix_d = '0;
            state_d  = LOAD;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      LOAD: begin
        if (pix_valid) begin
          matrix_d[wr_idx_c +: total_bits] = pix_data;
          if (col_q == cols_q - 4'd1) begin
            col_d = 4'd0;
            row_d = row_q + 4'd1;
          end else begin
            col_d = col_q + 4'd1;
          end
          if (final_c) state_d = DONE;
`ifdef MATRIX_LOADER_LAST_CHECK_EN
          // Early pix_last aborts the frame; a missing one is flagged but tolerated.
          if (pix_last && !final_c) begin
            err_d    = 1'b1;
            state_d  = IDLE;
            matrix_d = '0;
          end else if (!pix_last && final_c) begin
            err_d = 1'b1;
          end
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      row_q    <= 4'd0;
      col_q    <= 4'd0;
      rows_q   <= 4'd0;
      cols_q   <= 4'd0;
      matrix_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      row_q    <= row_d;
      col_q    <= col_d;
      rows_q   <= rows_d;
      cols_q   <= cols_d;
      matrix_q <= matrix_d;
      err_q    <= err_d;
    end
  end

  // Status outputs are pure decodes of the state register.
  assign pix_ready   = (state_q == LOAD);
  assign busy        = (state_q == LOAD);
  assign load_done   = (state_q == DONE);
  assign err         = err_q;
  assign matrix_data = matrix_q;

endmodule

// File: tb/tb_matrix_stream_loader.sv
// Scoreboard bench for matrix_stream_loader; accepted pixels are queued with
// their expected slot and checked against matrix_data once load_done rises.
module tb_matrix_stream_loader;

  localparam int unsigned TB = 16;
  localparam int unsigned MR = 8;
  localparam int unsigned MC = 8;

  typedef struct {
    int          slot;
    logic [15:0] val;
  } sb_entry_t;

  logic                 clk, rst_n, start, pix_valid, pix_last;
  logic [3:0]           rows, cols;
  logic [TB-1:0]        pix_data;
  logic                 pix_ready, busy, load_done, err;
  logic [MR*MC*TB-1:0]  matrix_data;

  sb_entry_t sb_q[$];
  int n_cmp, n_err;

  matrix_stream_loader #(.total_bits(TB), .max_rows(MR), .max_cols(MC)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .rows(rows), .cols(cols),
    .pix_valid(pix_valid), .pix_data(pix_data), .pix_last(pix_last),
    .pix_ready(pix_ready), .matrix_data(matrix_data), .busy(busy),
    .load_done(load_done), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] slot_val(input int s);
    return matrix_data[s*TB +: TB];
  endfunction

  // Called at a falling edge; returns at the next falling edge.
  task automatic start_frame(input int r, input int c);
    start = 1'b1;
    rows  = 4'(r);
    cols  = 4'(c);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Offers npix pixels; each accepted one is queued with its expected slot.
  task automatic load_frame(input int r, input int c, input int npix, input bit stall,
                            input int base, input int lastpos, input int midstart);
    int n, cyc;
    bit v, pulsed;
    sb_entry_t e;
    n = 0; cyc = 0; v = 1'b1; pulsed = 1'b0;
    while (n < npix && cyc < 1000) begin
      pix_valid = v;
      pix_data  = 16'(base + n);
      pix_last  = (n == lastpos);
      start     = 1'b0;
      if (n == midstart && !pulsed && v) begin
        start = 1'b1; rows = 4'd3; cols = 4'd3; pulsed = 1'b1;
      end
      if (pix_valid && pix_ready) begin
        e.slot = (n / c) * int'(MC) + (n % c);
        e.val  = pix_data;
        sb_q.push_back(e);
        n++;
      end
      if (stall) v = !v;
      cyc++;
      @(negedge clk);
    end
    pix_valid = 1'b0;
    pix_last  = 1'b0;
    start     = 1'b0;
    check("xfer_count", 32'(n), 32'(npix));
    if (r < 0) check("bad_rows", 32'(r), 32'd0);
  endtask

  // Pops the scoreboard into slot checks; unwritten slots must be zero.
  task automatic check_frame(input string tag);
    bit written[MR*MC];
    int nz;
    sb_entry_t e;
    check({tag, "_done"}, 32'(load_done), 32'd1);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_ready"}, 32'(pix_ready), 32'd0);
    foreach (written[i]) written[i] = 1'b0;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      written[e.slot] = 1'b1;
      check({tag, "_slot"}, 32'(slot_val(e.slot)), 32'(e.val));
    end
    nz = 0;
    for (int s = 0; s < int'(MR * MC); s++)
      if (!written[s] && slot_val(s) != 16'd0) nz++;
    check({tag, "_zero_slots"}, 32'(nz), 32'd0);
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    rst_n = 1'b0; start = 1'b0; rows = 4'd0; cols = 4'd0;
    pix_valid = 1'b0; pix_data = '0; pix_last = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ready", 32'(pix_ready), 32'd0);
    check("rst_done", 32'(load_done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_matrix", 32'(|matrix_data), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Invalid size from IDLE
    start_frame(2, 4);
    check("inv_idle_err", 32'(err), 32'd1);
    check("inv_idle_busy", 32'(busy), 32'd0);
    @(negedge clk);
    check("inv_idle_err_drop", 32'(err), 32'd0);
    check("inv_idle_busy2", 32'(busy), 32'd0);

    // Reset in the middle of a 4x4 load
    start_frame(4, 4);
    check("mid_busy", 32'(busy), 32'd1);
    load_frame(4, 4, 7, 1'b0, 16'h0010, -1, -1);
    check("mid_partial_nz", 32'(|matrix_data), 32'd1);
    rst_n = 1'b0;
    #1;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_ready", 32'(pix_ready), 32'd0);
    check("arst_done", 32'(load_done), 32'd0);
    check("arst_err", 32'(err), 32'd0);
    check("arst_matrix", 32'(|matrix_data), 32'd0);
    sb_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    start_frame(3, 3);
    load_frame(3, 3, 9, 1'b0, 16'h0020, 8, -1);
    check_frame("f3x3");

    // Full 8x8 frame, valid held high
    start_frame(8, 8);
    load_frame(8, 8, 64, 1'b0, 16'h0100, 63, -1);
    check("f8x8_slot77", 32'(matrix_data[1023:1008]), 32'h013F);
    check_frame("f8x8");

    // 4x5 frame with alternating stalls
    start_frame(4, 5);
    load_frame(4, 5, 20, 1'b1, 1, 19, -1);
    check("f4x5_slot10", 32'(matrix_data[143:128]), 32'd6);
    check("f4x5_slot05", 32'(matrix_data[5*16 +: 16]), 32'd0);
    check_frame("f4x5");

    // Invalid size while DONE keeps the frame
    start_frame(3, 2);
    check("inv_done_err", 32'(err), 32'd1);
    check("inv_done_held", 32'(load_done), 32'd1);
    check("inv_done_slot0", 32'(slot_val(0)), 32'd1);
    check("inv_done_slot34", 32'(slot_val(3 * 8 + 4)), 32'd20);
    @(negedge clk);
    check("inv_done_err_drop", 32'(err), 32'd0);

    // Reload: 3x3, idle in DONE, then 5x5 with a stray start mid-load
    start_frame(3, 3);
    load_frame(3, 3, 9, 1'b0, 16'h0040, 8, -1);
    check_frame("r3x3");
    repeat (5) @(negedge clk);
    check("r_done_hold", 32'(load_done), 32'd1);
    start_frame(5, 5);
    check("r_done_drop", 32'(load_done), 32'd0);
    check("r_cleared", 32'(|matrix_data), 32'd0);
    check("r_busy", 32'(busy), 32'd1);
    load_frame(5, 5, 25, 1'b0, 16'h0200, 24, 6);
    check_frame("r5x5");

`ifdef MATRIX_LOADER_LAST_CHECK_EN
    // Early pix_last aborts the frame
    start_frame(3, 3);
    load_frame(3, 3, 4, 1'b0, 16'h0300, 3, -1);
    check("last_early_err", 32'(err), 32'd1);
    check("last_early_busy", 32'(busy), 32'd0);
    check("last_early_done", 32'(load_done), 32'd0);
    check("last_early_matrix", 32'(|matrix_data), 32'd0);
    sb_q.delete();
    @(negedge clk);
    // Missing pix_last on the final pixel still completes
    start_frame(3, 3);
    load_frame(3, 3, 9, 1'b0, 16'h0400, -1, -1);
    check("last_missing_err", 32'(err), 32'd1);
    check_frame("last_missing");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
